// File: rtl/text_cursor_ctrl_pkg.sv
// text_cursor_ctrl_pkg: character codes and state encoding shared by the text cursor controller
package text_cursor_ctrl_pkg;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BLANK    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;
    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/text_cursor_ctrl_clear_sweeper.sv
// text_cursor_ctrl_clear_sweeper: cell index counter that walks every screen cell once
module text_cursor_ctrl_clear_sweeper #(
    parameter int ROW_W = 2,
    parameter int COL_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             done
);
    logic [ROW_W+COL_W-1:0] idx, addr;
    // start emits cell 0 itself, so idx always names the next cell and wraps to 0 after the last
    assign addr       = start ? '0 : idx;
    assign {row, col} = addr;
    assign done       = idx == '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (start || step)
            idx <= addr + 1'b1;
    end
endmodule

// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: turns the received byte stream into character RAM writes,
// owning the write cursor, control characters and the clear-screen sweep.
module text_cursor_ctrl
    import text_cursor_ctrl_pkg::*;
#(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 4,
    parameter logic [7:0] BLANK = CH_BLANK,
    localparam int        COL_W = $clog2(COLS),
    localparam int        ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             overflow
);
    state_t           state;
    logic             hold_full;
    logic [7:0]       hold_byte;
    logic             have;
    logic [7:0]       byte_in;
    logic             at_end_col, at_origin;
    logic [ROW_W-1:0] adv_row, bs_row, sw_row;
    logic [COL_W-1:0] adv_col, bs_col, sw_col;
    logic             sw_start, sw_done;

    // a held byte always wins over the live strobe so ordering is preserved
    assign have       = hold_full | rx_valid;
    assign byte_in    = hold_full ? hold_byte : rx_data;
    assign at_end_col = cursor_col == COL_W'(COLS - 1);
    assign at_origin  = (cursor_row == '0) && (cursor_col == '0);
    assign adv_col    = cursor_col + 1'b1;
    assign adv_row    = at_end_col ? cursor_row + 1'b1 : cursor_row;
    assign bs_col     = at_origin ? cursor_col : cursor_col - 1'b1;
    assign bs_row     = ((cursor_col == '0) && !at_origin) ? cursor_row - 1'b1 : cursor_row;
    assign sw_start   = (state == IDLE) && have && (byte_in == CH_FF);

    text_cursor_ctrl_clear_sweeper #(.ROW_W(ROW_W), .COL_W(COL_W)) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sw_start),
        .step  ((state == CLEAR) && !sw_done),
        .row   (sw_row),
        .col   (sw_col),
        .done  (sw_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_full  <= 1'b0;
            hold_byte  <= '0;
            ram_we     <= 1'b0;
            ram_row    <= '0;
            ram_col    <= '0;
            ram_wdata  <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
            overflow <= 1'b0;
            if (state == IDLE) begin
                hold_full <= hold_full & rx_valid;
                if (hold_full && rx_valid)
                    hold_byte <= rx_data;
                if (have) begin
                    if (byte_in >= CH_PRINT_LO && byte_in <= CH_PRINT_HI) begin
                        ram_we     <= 1'b1;
                        ram_row    <= cursor_row;
                        ram_col    <= cursor_col;
                        ram_wdata  <= byte_in;
                        cursor_row <= adv_row;
                        cursor_col <= adv_col;
                    end else if (byte_in == CH_CR) begin
                        cursor_col <= '0;
                    end else if (byte_in == CH_LF) begin
                        cursor_row <= cursor_row + 1'b1;
                    end else if (byte_in == CH_BS) begin
                        ram_we     <= 1'b1;
                        ram_row    <= bs_row;
                        ram_col    <= bs_col;
                        ram_wdata  <= BLANK;
                        cursor_row <= bs_row;
                        cursor_col <= bs_col;
                    end else if (byte_in == CH_FF) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_row   <= sw_row;
                        ram_col   <= sw_col;
                        ram_wdata <= BLANK;
                    end
                end
            end else begin
                if (rx_valid) begin
                    overflow  <= hold_full;
                    hold_full <= 1'b1;
                    if (!hold_full)
                        hold_byte <= rx_data;
                end
                if (!sw_done) begin
                    ram_we    <= 1'b1;
                    ram_row   <= sw_row;
                    ram_col   <= sw_col;
                    ram_wdata <= BLANK;
                end else begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    cursor_row <= '0;
                    cursor_col <= '0;
                end
            end
        end
    end
endmodule
